// File: rtl/dc_bu_pkg.sv
// -----------------------------------------------------------------------------
// dc_bu_pkg
// Shared types and constants for the buffering-unit read side.
//   rd_seq_state_t  : read sequencer FSM states
//   RD_MEM_LATENCY  : cycles from re_vec/mem_addr to data at the buffer outputs
//   rep_max_of()    : converts a line_repeat value into the last pass index
// -----------------------------------------------------------------------------
package dc_bu_pkg;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_READ  = 2'd1,
    RS_DRAIN = 2'd2
  } rd_seq_state_t;

  localparam int RD_MEM_LATENCY = 1;

  // A repeat count of 0 is treated as a single pass.
  function automatic int unsigned rep_max_of(input int unsigned line_repeat);
    if (line_repeat == 32'd0) begin
      return 32'd0;
    end else begin
      return line_repeat - 32'd1;
    end
  endfunction

endpackage

// File: rtl/dc_bu_step_counter.sv
// -----------------------------------------------------------------------------
// dc_bu_step_counter
// Owns the read address and the repeat-pass counter of the read sequencer.
// Ports:
//   clk_i, nrst_i : clock, async active-low reset
//   step_i        : a read is issued this cycle; advance the address
//   clear_i       : abort; address and pass counter return to 0 (wins over step_i)
//   last_idx_i    : clamped index of the last pixel of the line
//   rep_max_i     : index of the last pass
//   addr_o        : current read address
//   final_o       : the current address is the last word of a pass
//   last_pass_o   : the current pass is the last one
// -----------------------------------------------------------------------------
module dc_bu_step_counter #(
  parameter int WIDTH     = 7,
  parameter int LANES     = 1,
  parameter int REP_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 step_i,
  input  logic                 clear_i,
  input  logic [WIDTH-1:0]     last_idx_i,
  input  logic [REP_WIDTH-1:0] rep_max_i,
  output logic [WIDTH-1:0]     addr_o,
  output logic                 final_o,
  output logic                 last_pass_o
);

  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [REP_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic [WIDTH:0]       next_addr_s;

  // One extra bit so that addr + LANES cannot wrap past the end of the buffer.
  assign next_addr_s = {1'b0, addr_q} + (WIDTH + 1)'(LANES);
  assign final_o     = (next_addr_s > {1'b0, last_idx_i});
  assign last_pass_o = (rep_cnt_q == rep_max_i);
  assign addr_o      = addr_q;

  // Next address / pass count; a finished pass wraps straight to address 0.
  always_comb begin
    addr_d    = addr_q;
    rep_cnt_d = rep_cnt_q;
    if (clear_i) begin
      addr_d    = '0;
      rep_cnt_d = '0;
    end else if (step_i) begin
      if (!final_o) begin
        addr_d = next_addr_s[WIDTH-1:0];
      end else if (last_pass_o) begin
        addr_d    = '0;
        rep_cnt_d = '0;
      end else begin
        addr_d    = '0;
        rep_cnt_d = rep_cnt_q + REP_WIDTH'(1);
      end
    end else begin
      addr_d    = addr_q;
      rep_cnt_d = rep_cnt_q;
    end
  end

  // Address and pass counter registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      addr_q    <= '0;
      rep_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/dc_bu_read_sequencer.sv
// -----------------------------------------------------------------------------
// dc_bu_read_sequencer
// Read-side controller for the line buffers. Reads every buffer except the one
// being written, LANES pixels per word, repeating each line line_repeat times,
// with a valid/ready handshake towards the scaler datapath.
// Ports:
//   clk, nrst        : clock, async active-low reset
//   en               : global enable; low freezes every register
//   pixels_per_line  : index of the last pixel of the line
//   line_repeat      : passes per line (0 behaves as 1)
//   start_line       : begin reading the current line set (only in IDLE)
//   reset_x          : abort to IDLE, highest priority
//   write_buffer_id  : one-hot id of the buffer being written (latched at start)
//   rd_ready         : downstream accepts the current word
//   mem_addr         : read address to all buffers
//   re_vec           : per-buffer read enables, one cycle ahead of the data
//   rd_valid         : read data valid at the buffer outputs
//   last_pixel       : final word of one pass (qualified by rd_valid)
//   line_released    : one-cycle pulse after the last word of the line is taken
//   busy             : sequencer is not idle
// -----------------------------------------------------------------------------
module dc_bu_read_sequencer
  import dc_bu_pkg::*;
#(
  parameter int BUFF_ADDR_WIDTH       = 7,
  parameter int BUFFER_SIZE           = 128,
  parameter int BUFFER_NUM            = 5,
  parameter int PIXELS_PER_LINE_WIDTH = 7,
  parameter int LANES                 = 1,
  parameter int REPEAT_WIDTH          = 3
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
  input  logic [REPEAT_WIDTH-1:0]          line_repeat,
  input  logic                             start_line,
  input  logic                             reset_x,
  input  logic [BUFFER_NUM-1:0]            write_buffer_id,
  input  logic                             rd_ready,
  output logic [BUFF_ADDR_WIDTH-1:0]       mem_addr,
  output logic [BUFFER_NUM-1:0]            re_vec,
  output logic                             rd_valid,
  output logic                             last_pixel,
  output logic                             line_released,
  output logic                             busy
);

  rd_seq_state_t              state_q;
  logic [BUFFER_NUM-1:0]      id_lat_q;
  logic [BUFF_ADDR_WIDTH-1:0] last_idx_q;
  logic [REPEAT_WIDTH-1:0]    rep_max_q;
  logic                       rd_valid_q;
  logic                       last_pixel_q;
  logic                       line_released_q;

  logic [BUFF_ADDR_WIDTH-1:0] last_idx_s;
  logic [REPEAT_WIDTH-1:0]    rep_max_s;
  logic [BUFF_ADDR_WIDTH-1:0] addr_s;
  logic                       final_s;
  logic                       last_pass_s;
  logic                       issue_s;
  logic                       accept_s;
  logic                       clear_s;

  // A new read may go out when the output slot is empty or is being drained.
  assign issue_s  = en & (state_q == RS_READ) & (~rd_valid_q | rd_ready);
  assign accept_s = en & rd_valid_q & rd_ready;
  assign clear_s  = en & reset_x;

  // Clamp the line length to the buffer and the repeat count to at least one pass.
  always_comb begin
    last_idx_s = '0;
    if (32'(pixels_per_line) > 32'(BUFFER_SIZE - 1)) begin
      last_idx_s = BUFF_ADDR_WIDTH'(BUFFER_SIZE - 1);
    end else begin
      last_idx_s = BUFF_ADDR_WIDTH'(pixels_per_line);
    end
    rep_max_s = REPEAT_WIDTH'(rep_max_of(32'(line_repeat)));
  end

  dc_bu_step_counter #(
    .WIDTH     (BUFF_ADDR_WIDTH),
    .LANES     (LANES),
    .REP_WIDTH (REPEAT_WIDTH)
  ) u_step_counter (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .step_i      (issue_s),
    .clear_i     (clear_s),
    .last_idx_i  (last_idx_q),
    .rep_max_i   (rep_max_q),
    .addr_o      (addr_s),
    .final_o     (final_s),
    .last_pass_o (last_pass_s)
  );

  // Sequencer FSM, handshake register and line parameter latches.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= RS_IDLE;
      id_lat_q        <= '0;
      last_idx_q      <= '0;
      rep_max_q       <= '0;
      rd_valid_q      <= 1'b0;
      last_pixel_q    <= 1'b0;
      line_released_q <= 1'b0;
    end else if (en) begin
      line_released_q <= 1'b0;
      if (reset_x) begin
        state_q      <= RS_IDLE;
        rd_valid_q   <= 1'b0;
        last_pixel_q <= 1'b0;
      end else begin
        // Data appears one cycle after the read; a stalled word keeps its flags.
        if (issue_s) begin
          rd_valid_q   <= 1'b1;
          last_pixel_q <= final_s;
        end else if (rd_ready) begin
          rd_valid_q <= 1'b0;
        end

        case (state_q)
          RS_IDLE: begin
            if (start_line) begin
              state_q    <= RS_READ;
              id_lat_q   <= write_buffer_id;
              last_idx_q <= last_idx_s;
              rep_max_q  <= rep_max_s;
            end
          end
          RS_READ: begin
            if (issue_s && final_s && last_pass_s) begin
              state_q <= RS_DRAIN;
            end
          end
          RS_DRAIN: begin
            // Only the final word of the line is outstanding here.
            if (accept_s) begin
              state_q         <= RS_IDLE;
              line_released_q <= 1'b1;
            end
          end
          default: begin
            state_q <= RS_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_addr      = addr_s;
  assign re_vec        = issue_s ? ~id_lat_q : '0;
  assign rd_valid      = rd_valid_q;
  assign last_pixel    = rd_valid_q & last_pixel_q;
  assign line_released = line_released_q;
  assign busy          = (state_q != RS_IDLE);

endmodule
